sdiv_pipe: RTL and testbench
============================

# sdiv_pipe

Fully pipelined signed integer divider with valid/ready flow control, per-transaction tag, configurable radix (quotient bits per stage), overflow flag and optional divide-by-zero detection. Successor to the fixed-latency, no-backpressure signed divider in the algorithm library. Sits between producers and consumers that need one divide per clock with stall capability.

## Interface
- N, 40, dividend/quotient width (signed)
- M, 20, divisor/remainder width (signed)
- BPS, 1, quotient bits resolved per pipeline stage; legal 1, 2, 4; N % BPS == 0 required (elaboration error otherwise)
- TW, 4, tag width; tag is carried unmodified alongside data
- clk  in  1  clock, all logic rising-edge
- rstn  in  1  synchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  divider can accept
- in_dividend  in  N  signed dividend
- in_divisor  in  M  signed divisor
- in_tag  in  TW  user tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_quotient  out  N  signed quotient
- out_remainder  out  M  signed remainder
- out_tag  out  TW  tag of this result
- out_ovf  out  1  quotient overflow (-2^(N-1) / -1)
- out_dbz  out  1  divisor was zero

## Operation
- Truncating division: quotient rounds toward zero; remainder sign = dividend sign (or 0); dividend = q*divisor + r for all non-flagged cases.
- Stage 0 (input reg): capture tag, sign bits, |dividend| (N-bit unsigned, -2^(N-1) maps to 2^(N-1)), |divisor| (M-bit unsigned), ovf/dbz detection.
- Stages 1..N/BPS: restoring division, BPS quotient bits per stage, MSB first; partial remainder M+1 bits wide.
- Final stage: sign fix-up: quotient negated if signs differ, remainder negated if dividend negative.
- Overflow: quotient wraps to -2^(N-1), remainder 0, out_ovf=1.
- Each stage holds a valid bit; data advances with its valid, order strictly preserved.
- Flow control: global stall. stall = out_valid & ~out_ready. When stall, no stage register updates. in_ready = ~stall (combinational).
- Accept on in_valid & in_ready; output transfer on out_valid & out_ready.
- Bubbles propagate; valid bits shift even when empty stages exist (no bubble collapsing).

## Timing
- Latency L = N/BPS + 2 cycles from accept to out_valid with no stall (N=40, BPS=1: 42).
- Throughput 1 result/cycle when out_ready held high.
- Reset (rstn=0 at posedge): all valid bits 0; out_valid=0, out_quotient=0, out_remainder=0, out_tag=0, out_ovf=0, out_dbz=0; in_ready=1 the cycle after. Reset mid-operation discards all in-flight transactions; none emerge later.
- Stall holds out_* stable until transfer.
- in_valid while in_ready=0: no accept; producer must hold data (standard valid/ready).
- Simultaneous accept and output transfer in same cycle is allowed and required.

## Configuration
- SDIV_DBZ_EN defined: divisor==0 detected in stage 0; result quotient = -1 (all ones), remainder = 0, out_dbz=1, out_ovf=0.
- Not defined: detection logic absent; out_dbz tied 0; quotient/remainder for zero divisor undefined (not checked by bench).

## Structure
- Package sdiv_pkg: latency function sdiv_latency(N,BPS), flags struct {ovf, dbz}, sign-bit pair struct.
- Sub-module sdiv_stage: one BPS-bit restoring step (combinational step plus stage register with enable and valid), instantiated N/BPS times via generate.
- Top holds stage 0, final fix-up stage, stall logic.

## Test plan
- 100 / 7 -> q=14, r=2; -100 / 7 -> q=-14, r=-2; 100 / -7 -> q=-14, r=2; -100 / -7 -> q=14, r=-2; latency exactly 42 cycles (N=40, M=20, BPS=1).
- -2^39 / -1 -> q=-2^39, r=0, out_ovf=1; -2^39 / -2^19 -> q=2^20, r=0, ovf=0.
- With SDIV_DBZ_EN: 5 / 0 -> q=-1, r=0, out_dbz=1; without macro out_dbz stays 0.
- 8 back-to-back inputs, tags 0..7, out_ready low 5 cycles mid-stream -> in_ready low during stall, all 8 results in tag order, none lost/duplicated, outputs stable while stalled.
- 10k random operands, BPS=1,2,4, random in_valid/out_ready -> match reference model; latency N/BPS+2 when unstalled.
- rstn low for 1 cycle with 20 transactions in flight -> out_valid=0 next cycle, no stale results afterwards, next accepted input returns correctly after L cycles.

Source files
------------

// File: rtl/sdiv_pkg.sv
// sdiv_pkg: shared types and helpers for the pipelined signed divider.
package sdiv_pkg;

  // Accept-to-out_valid latency in clock cycles for an unstalled pipe.
  function automatic int sdiv_latency(input int n, input int bps);
    return n / bps + 2;
  endfunction

  // Exception flags that travel alongside each transaction.
  typedef struct packed {
    logic ovf;  // -2^(N-1) / -1
    logic dbz;  // divisor was zero
  } sdiv_flags_t;

  // Operand signs, captured at the input and used by the final fix-up.
  typedef struct packed {
    logic dvd_neg;
    logic dvs_neg;
  } sdiv_signs_t;

  localparam int SDIV_FLAGS_W = $bits(sdiv_flags_t);
  localparam int SDIV_SIGNS_W = $bits(sdiv_signs_t);

endpackage

// File: rtl/sdiv_stage.sv
// sdiv_stage: one pipeline stage of the restoring divider. Resolves BPS
// quotient bits (MSB first) and registers the result with its valid bit.
// The dividend/quotient share one shift register: dividend bits leave at
// the top while quotient bits enter at the bottom.
module sdiv_stage
  import sdiv_pkg::*;
#(
  parameter int N   = 40,
  parameter int M   = 20,
  parameter int BPS = 1,
  parameter int SW  = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [M-1:0] i_rem,
  input  logic [N-1:0] i_dq,
  input  logic [M-1:0] i_dvs,
  input  logic [SW-1:0] i_side,
  output logic         o_valid,
  output logic [M-1:0] o_rem,
  output logic [N-1:0] o_dq,
  output logic [M-1:0] o_dvs,
  output logic [SW-1:0] o_side
);

  logic [M-1:0]  w_rem_nxt;
  logic [N-1:0]  w_dq_nxt;
  logic [M:0]    w_trial;

  logic          r_valid;
  logic [M-1:0]  r_rem;
  logic [N-1:0]  r_dq;
  logic [M-1:0]  r_dvs;
  logic [SW-1:0] r_side;

  // BPS restoring steps: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    // NOTE: blocking assignments are intentional here; each iteration must
    // see the previous iteration's partial remainder in the same evaluation.
    w_rem_nxt = i_rem;
    w_dq_nxt  = i_dq;
    w_trial   = '0;
    for (int b = 0; b < BPS; b++) begin
      w_trial  = {w_rem_nxt, w_dq_nxt[N-1]};
      w_dq_nxt = {w_dq_nxt[N-2:0], 1'b0};
      if (w_trial >= {1'b0, i_dvs}) begin
        w_trial     = w_trial - {1'b0, i_dvs};
        w_dq_nxt[0] = 1'b1;
      end
      w_rem_nxt = w_trial[M-1:0];
    end
  end

  // Valid bit: cleared by reset, advances only while the pipe is not stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
    end
  end

  // Payload registers follow their valid bit.
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; the valid bit alone qualifies
    // it, which keeps reset off the wide datapath.
    if (i_en) begin
      r_rem  <= w_rem_nxt;
      r_dq   <= w_dq_nxt;
      r_dvs  <= i_dvs;
      r_side <= i_side;
    end
  end

  assign o_valid = r_valid;
  assign o_rem   = r_rem;
  assign o_dq    = r_dq;
  assign o_dvs   = r_dvs;
  assign o_side  = r_side;

endmodule

// File: rtl/sdiv_pipe.sv
// sdiv_pipe: fully pipelined signed truncating divider with valid/ready,
// tag passthrough and overflow flag. Stage 0 takes magnitudes and flags,
// N/BPS sdiv_stage instances do the restoring division, a final stage
// restores signs. A single global stall freezes every register.
// Optional feature: define SDIV_DBZ_EN to detect divide-by-zero
// (quotient -1, remainder 0, out_dbz=1); otherwise out_dbz is tied low.
module sdiv_pipe
  import sdiv_pkg::*;
#(
  parameter int N   = 40,
  parameter int M   = 20,
  parameter int BPS = 1,
  parameter int TW  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_dividend,
  input  logic signed [M-1:0] in_divisor,
  input  logic [TW-1:0]       in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_quotient,
  output logic signed [M-1:0] out_remainder,
  output logic [TW-1:0]       out_tag,
  output logic                out_ovf,
  output logic                out_dbz
);

  localparam int S  = N / BPS;
  localparam int SW = TW + SDIV_SIGNS_W + SDIV_FLAGS_W;
  localparam logic signed [N-1:0] MIN_DVD = {1'b1, {(N-1){1'b0}}};

  if (!(BPS == 1 || BPS == 2 || BPS == 4) || (N % BPS) != 0) begin : g_bad_cfg
    $error("sdiv_pipe: BPS must be 1, 2 or 4 and divide N");
  end

  // ---------------- flow control ----------------
  logic w_stall;
  logic w_en;

  logic                r_out_valid;
  logic signed [N-1:0] r_out_quotient;
  logic signed [M-1:0] r_out_remainder;
  logic [TW-1:0]       r_out_tag;
  logic                r_out_ovf;
  logic                r_out_dbz;

  assign w_stall  = r_out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  // ---------------- stage 0 ----------------
  sdiv_signs_t  w_in_signs;
  sdiv_flags_t  w_in_flags;
  logic [N-1:0] w_dvd_abs;
  logic [M-1:0] w_dvs_abs;

  logic          r0_valid;
  logic [N-1:0]  r0_dvd_abs;
  logic [M-1:0]  r0_dvs_abs;
  logic [SW-1:0] r0_side;

  // Operand magnitudes and exception detection; -2^(N-1) maps to 2^(N-1).
  always_comb begin
    w_in_signs.dvd_neg = in_dividend[N-1];
    w_in_signs.dvs_neg = in_divisor[M-1];
    w_dvd_abs = w_in_signs.dvd_neg ? -in_dividend : in_dividend;
    w_dvs_abs = w_in_signs.dvs_neg ? -in_divisor  : in_divisor;
    w_in_flags.ovf = (in_dividend == MIN_DVD) && (&in_divisor);
`ifdef SDIV_DBZ_EN
    w_in_flags.dbz = ~|in_divisor;
`else
    w_in_flags.dbz = 1'b0;
`endif
  end

  // Stage 0 valid: accept whenever in_valid is seen while not stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r0_valid <= 1'b0;
    end else if (w_en) begin
      r0_valid <= in_valid;
    end
  end

  // Stage 0 payload.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r0_dvd_abs <= w_dvd_abs;
      r0_dvs_abs <= w_dvs_abs;
      r0_side    <= {in_tag, w_in_signs, w_in_flags};
    end
  end

  // ---------------- restoring stages ----------------
  logic          w_valid [0:S];
  logic [M-1:0]  w_rem   [0:S];
  logic [N-1:0]  w_dq    [0:S];
  logic [M-1:0]  w_dvs   [0:S];
  logic [SW-1:0] w_side  [0:S];

  assign w_valid[0] = r0_valid;
  assign w_rem[0]   = '0;
  assign w_dq[0]    = r0_dvd_abs;
  assign w_dvs[0]   = r0_dvs_abs;
  assign w_side[0]  = r0_side;

  for (genvar gi = 0; gi < S; gi++) begin : g_stage
    sdiv_stage #(
      .N   (N),
      .M   (M),
      .BPS (BPS),
      .SW  (SW)
    ) u_stage (
      .clk     (clk),
      .rstn    (rstn),
      .i_en    (w_en),
      .i_valid (w_valid[gi]),
      .i_rem   (w_rem[gi]),
      .i_dq    (w_dq[gi]),
      .i_dvs   (w_dvs[gi]),
      .i_side  (w_side[gi]),
      .o_valid (w_valid[gi+1]),
      .o_rem   (w_rem[gi+1]),
      .o_dq    (w_dq[gi+1]),
      .o_dvs   (w_dvs[gi+1]),
      .o_side  (w_side[gi+1])
    );
  end

  // The divisor is not needed past the last stage.
  logic w_unused_dvs;
  assign w_unused_dvs = &{1'b0, w_dvs[S]};

  // ---------------- final fix-up stage ----------------
  logic [TW-1:0] w_fin_tag;
  sdiv_signs_t   w_fin_signs;
  sdiv_flags_t   w_fin_flags;
  logic [N-1:0]  w_quot_fix;
  logic [M-1:0]  w_rem_fix;

  assign {w_fin_tag, w_fin_signs, w_fin_flags} = w_side[S];

  // Sign restoration with exception overrides.
  always_comb begin
    // NOTE: both results get a value on every path before any override,
    // so this block cannot infer a latch.
    w_quot_fix = (w_fin_signs.dvd_neg ^ w_fin_signs.dvs_neg) ? -w_dq[S] : w_dq[S];
    w_rem_fix  = w_fin_signs.dvd_neg ? -w_rem[S] : w_rem[S];
    if (w_fin_flags.ovf) begin
      w_quot_fix = MIN_DVD;
      w_rem_fix  = '0;
    end
`ifdef SDIV_DBZ_EN
    if (w_fin_flags.dbz) begin
      w_quot_fix = '1;
      w_rem_fix  = '0;
    end
`endif
  end

  // Output register: fully reset, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid     <= 1'b0;
      r_out_quotient  <= '0;
      r_out_remainder <= '0;
      r_out_tag       <= '0;
      r_out_ovf       <= 1'b0;
      r_out_dbz       <= 1'b0;
    end else if (w_en) begin
      r_out_valid     <= w_valid[S];
      r_out_quotient  <= w_quot_fix;
      r_out_remainder <= w_rem_fix;
      r_out_tag       <= w_fin_tag;
      r_out_ovf       <= w_fin_flags.ovf;
      r_out_dbz       <= w_fin_flags.dbz;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_quotient  = r_out_quotient;
  assign out_remainder = r_out_remainder;
  assign out_tag       = r_out_tag;
  assign out_ovf       = r_out_ovf;
  assign out_dbz       = r_out_dbz;

endmodule

// File: tb/tb_sdiv_pipe.sv
// tb_sdiv_pipe: scoreboard bench for sdiv_pipe. Expected results come from
// a signed 64-bit arithmetic model and are queued on accept, compared on
// output transfer. Define SDIV_DBZ_EN to exercise divide-by-zero detection.
module tb_sdiv_pipe #(
  parameter int BPS = 1
);

  localparam int N  = 40;
  localparam int M  = 20;
  localparam int TW = 4;
  localparam int L  = N / BPS + 2;
  localparam longint MIN_N = -(longint'(1) << (N - 1));
  localparam longint MAX_N = (longint'(1) << (N - 1)) - 1;
  localparam longint MIN_M = -(longint'(1) << (M - 1));
  localparam longint MAX_M = (longint'(1) << (M - 1)) - 1;
  localparam int NRAND = 10000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_dividend;
  logic [M-1:0]  in_divisor;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_quotient;
  logic [M-1:0]  out_remainder;
  logic [TW-1:0] out_tag;
  logic          out_ovf;
  logic          out_dbz;

  sdiv_pipe #(.N(N), .M(M), .BPS(BPS), .TW(TW)) u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_tag       (out_tag),
    .out_ovf       (out_ovf),
    .out_dbz       (out_dbz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]  q;
    logic [M-1:0]  r;
    logic [TW-1:0] tag;
    logic          ovf;
    logic          dbz;
    bit            flags_only;
    bit            chk_lat;
    int            acc;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  bit            drv_pending = 1'b0;
  longint        drv_a, drv_b;
  logic [TW-1:0] drv_tag;
  bit            lat_mode = 1'b0;
  bit            hold_prev = 1'b0;
  logic [N-1:0]      h_q;
  logic [M+TW+2:0]   h_rest;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Truncating signed division reference.
  function automatic exp_t model(input longint a, input longint b, input logic [TW-1:0] tag);
    exp_t   e;
    longint q64, r64;
    e.tag = tag; e.ovf = 1'b0; e.dbz = 1'b0;
    e.flags_only = 1'b0; e.chk_lat = 1'b0; e.acc = 0;
    e.q = '0; e.r = '0;
    if (b == 0) begin
`ifdef SDIV_DBZ_EN
      e.q = '1; e.dbz = 1'b1;
`else
      e.flags_only = 1'b1;
`endif
    end else begin
      q64 = a / b;
      r64 = a % b;
      e.q = q64[N-1:0];
      e.r = r64[M-1:0];
      e.ovf = (a == MIN_N) && (b == -1);
    end
    return e;
  endfunction

  // One clock: drive inputs at negedge, then sample handshakes and outputs.
  task automatic tick(input bit rdy);
    exp_t e;
    @(negedge clk);
    out_ready = rdy;
    in_valid  = drv_pending;
    if (drv_pending) begin
      in_dividend = drv_a[N-1:0];
      in_divisor  = drv_b[M-1:0];
      in_tag      = drv_tag;
    end
    #1;
    if (hold_prev) begin
      check("hold_q", 64'(out_quotient), 64'(h_q));
      check("hold_rest", 64'({out_remainder, out_tag, out_ovf, out_dbz, out_valid}), 64'(h_rest));
    end
    check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    hold_prev = out_valid && !out_ready;
    h_q    = out_quotient;
    h_rest = {out_remainder, out_tag, out_ovf, out_dbz, out_valid};
    if (in_valid && in_ready) begin
      e = model(drv_a, drv_b, drv_tag);
      e.acc = cyc;
      e.chk_lat = lat_mode;
      sb.push_back(e);
      drv_pending = 1'b0;
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        if (!e.flags_only) begin
          check("quotient", 64'(out_quotient), 64'(e.q));
          check("remainder", 64'(out_remainder), 64'(e.r));
        end
        check("tag", 64'(out_tag), 64'(e.tag));
        check("ovf", 64'(out_ovf), 64'(e.ovf));
        check("dbz", 64'(out_dbz), 64'(e.dbz));
        if (e.chk_lat) check("latency", 64'(cyc - e.acc), 64'(L));
      end
    end
  endtask

  task automatic send(input longint a, input longint b, input logic [TW-1:0] tag, input bit rdy);
    drv_a = a; drv_b = b; drv_tag = tag; drv_pending = 1'b1;
    for (int k = 0; k < 200 && drv_pending; k++) tick(rdy);
    if (drv_pending) begin
      check("accept_timeout", 64'(0), 64'(1));
      drv_pending = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() > 0; k++) tick(1'b1);
    if (sb.size() > 0) begin
      check("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  function automatic longint rnd_dvd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return MIN_N;
      1: return -1;
      2: return 0;
      3: return MAX_N;
      default: return longint'($signed(t[N-1:0]));
    endcase
  endfunction

  function automatic longint rnd_dvs();
    logic [31:0] t;
    longint      v;
    t = $urandom;
    case ($urandom_range(0, 7))
      0: v = MIN_M;
      1: v = -1;
      2: v = 1;
      3: v = MAX_M;
      4: v = longint'($signed(t[4:0]));
      default: v = longint'($signed(t[M-1:0]));
    endcase
`ifndef SDIV_DBZ_EN
    if (v == 0) v = 3;
`endif
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sent;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_quotient", 64'(out_quotient), 64'(0));
    check("rst_remainder", 64'(out_remainder), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    check("rst_flags", 64'({out_ovf, out_dbz}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rstn = 1'b1;

    // Directed sign cases, overflow, extremes, zero divisor; latency checked.
    lat_mode = 1'b1;
    send(100, 7, 4'd1, 1'b1);
    send(-100, 7, 4'd2, 1'b1);
    send(100, -7, 4'd3, 1'b1);
    send(-100, -7, 4'd4, 1'b1);
    send(MIN_N, -1, 4'd5, 1'b1);
    send(MIN_N, MIN_M, 4'd6, 1'b1);
    send(MAX_N, MIN_M, 4'd7, 1'b1);
    send(-1, MAX_M, 4'd8, 1'b1);
    send(5, 0, 4'd9, 1'b1);
    send(MIN_N, 1, 4'd10, 1'b1);
    drain(L + 40);
    lat_mode = 1'b0;

    // Back-to-back burst with a 5-cycle consumer stall mid-stream.
    base = n_out;
    for (int t = 0; t < 8; t++) send(longint'(t) * 1000 + 123, -(t + 3), 4'(t), 1'b1);
    for (int k = 0; k < 200 && n_out < base + 3; k++) tick(1'b1);
    drv_a = -77777; drv_b = 9; drv_tag = 4'd8; drv_pending = 1'b1;
    repeat (5) tick(1'b0);
    drain(L + 40);
    check("stall_count", 64'(n_out - base), 64'(9));

    // Random operands with random in_valid / out_ready.
    sent = 0;
    for (int k = 0; k < 60000 && (sent < NRAND || drv_pending); k++) begin
      if (!drv_pending && sent < NRAND && $urandom_range(0, 3) != 0) begin
        drv_a = rnd_dvd(); drv_b = rnd_dvs(); drv_tag = 4'($urandom);
        drv_pending = 1'b1;
        sent++;
      end
      tick($urandom_range(0, 3) != 0);
    end
    check("rand_all_sent", 64'(sent), 64'(NRAND));
    drv_pending = 1'b0;
    drain(L + 200);

    // Reset with transactions in flight: nothing stale may emerge.
    for (int t = 0; t < 20; t++) send(longint'(t) + 500, 3, 4'(t), 1'b1);
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; drv_pending = 1'b0;
    @(negedge clk);
    #1;
    sb.delete();
    hold_prev = 1'b0;
    check("rst2_out_valid", 64'(out_valid), 64'(0));
    check("rst2_in_ready", 64'(in_ready), 64'(1));
    rstn = 1'b1;
    base = n_out;
    repeat (L + 10) tick(1'b1);
    check("rst2_no_stale", 64'(n_out - base), 64'(0));
    lat_mode = 1'b1;
    send(12345, 67, 4'd11, 1'b1);
    drain(L + 20);
    check("rst2_one_out", 64'(n_out - base), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
